// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer: mode codes,
// pattern geometry, and the pattern-bit to LED bank mapping.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALT    = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam int LED_COUNT = 18;
  localparam int POS_W     = 5;

  localparam logic [LED_COUNT-1:0] ALT_PATTERN = 18'h15555;
  localparam logic [POS_W-1:0]     POS_MAX     = 5'(LED_COUNT - 1);

  // Pattern bits 7..0 drive the green bank, bits 17..8 the red bank.
  localparam int LEDG_LSB = 0;
  localparam int LEDG_W   = 8;
  localparam int LEDR_LSB = 8;
  localparam int LEDR_W   = 10;

  function automatic logic [LED_COUNT-1:0] pattern_of(
    input mode_e            mode,
    input logic [POS_W-1:0] pos,
    input logic             phase
  );
    logic [LED_COUNT-1:0] pat;
    pat = '0;
    case (mode)
      MODE_ALT:    pat = phase ? ~ALT_PATTERN : ALT_PATTERN;
      MODE_CHASE,
      MODE_BOUNCE: pat = {{(LED_COUNT-1){1'b0}}, 1'b1} << pos;
      default:     pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate tick generator: counts 0..P-1 with P = BASE_DIV >> speed_i,
// holds while hold_i is high, and restarts from zero on clear_i.
module led_tick_gen #(
  parameter int BASE_DIV = 25_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] speed_i,
  input  logic       hold_i,
  input  logic       clear_i,
  output logic       tick_o
);

  localparam int CW = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   limit;

  // The >= compare lets a shortened period that is already overrun tick at once.
  always_comb begin
    limit  = (32'(BASE_DIV) >> speed_i) - 32'd1;
    tick_o = !hold_i && (32'(cnt_q) >= limit);
    cnt_d  = cnt_q + CW'(1);
    if (clear_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer (OFF/ALT/CHASE/BOUNCE) with pause and single-step keys.
// Define LED_SEQ_DEBOUNCE_EN to debounce the synchronized keys before edge detection.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int BASE_DIV     = 25_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic [9:0] SW,
  input  logic [3:0] KEY,
  output logic [9:0] LEDR,
  output logic [7:0] LEDG,
  output logic       paused
);

  logic [3:0] sw_s1_q, sw_s2_q;
  logic [1:0] key_s1_q, key_s2_q;
  logic [1:0] key_lvl, key_prev_q, key_press;
  logic       pause_press, step_press;

  logic unused_io;
  assign unused_io = ^{SW[9:4], KEY[3:2]};

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int DCW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]     key_db_q;
  logic [DCW-1:0] db_cnt_q [2];

  // A differing level must persist for DEBOUNCE_CYC samples to be accepted.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      key_db_q <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (key_s2_q[i] == key_db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (32'(db_cnt_q[i]) >= 32'(DEBOUNCE_CYC - 1)) begin
          key_db_q[i] <= key_s2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  assign key_lvl = key_db_q;
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYC != 0);
  assign key_lvl    = key_s2_q;
`endif

  assign key_press   = key_prev_q & ~key_lvl;
  assign pause_press = key_press[0];
  assign step_press  = key_press[1];

  logic  tick, adv;
  mode_e mode_q, mode_d, mode_sel;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 dir_dn_q, dir_dn_d;
  logic                 phase_q, phase_d;
  logic                 paused_q, paused_d;
  logic [LED_COUNT-1:0] led_q, led_d;

  led_tick_gen #(
    .BASE_DIV(BASE_DIV)
  ) u_tick (
    .clk_i   (CLOCK_50),
    .rst_i   (RST),
    .speed_i (sw_s2_q[3:2]),
    .hold_i  (paused_q),
    .clear_i (step_press & paused_q),
    .tick_o  (tick)
  );

  // Step is qualified by the pre-toggle paused value.
  assign adv      = tick | (step_press & paused_q);
  assign mode_sel = mode_e'(sw_s2_q[1:0]);

  always_comb begin
    mode_d   = mode_q;
    pos_d    = pos_q;
    dir_dn_d = dir_dn_q;
    phase_d  = phase_q;
    paused_d = paused_q ^ pause_press;
    if (adv) begin
      if (mode_sel != mode_q) begin
        mode_d   = mode_sel;
        pos_d    = '0;
        dir_dn_d = 1'b0;
        phase_d  = 1'b0;
      end else begin
        case (mode_q)
          MODE_ALT:   phase_d = ~phase_q;
          MODE_CHASE: pos_d   = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
          MODE_BOUNCE: begin
            // Direction flips on arrival so neither end position repeats.
            if (!dir_dn_q) begin
              pos_d = pos_q + POS_W'(1);
              if (pos_d == POS_MAX) dir_dn_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
              if (pos_d == '0) dir_dn_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
    led_d = pattern_of(mode_d, pos_d, phase_d);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      key_s1_q   <= 2'b11;
      key_s2_q   <= 2'b11;
      key_prev_q <= 2'b11;
      mode_q     <= MODE_OFF;
      pos_q      <= '0;
      dir_dn_q   <= 1'b0;
      phase_q    <= 1'b0;
      paused_q   <= 1'b0;
      led_q      <= '0;
    end else begin
      sw_s1_q    <= SW[3:0];
      sw_s2_q    <= sw_s1_q;
      key_s1_q   <= KEY[1:0];
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_lvl;
      mode_q     <= mode_d;
      pos_q      <= pos_d;
      dir_dn_q   <= dir_dn_d;
      phase_q    <= phase_d;
      paused_q   <= paused_d;
      led_q      <= led_d;
    end
  end

  assign LEDG   = led_q[LEDG_LSB +: LEDG_W];
  assign LEDR   = led_q[LEDR_LSB +: LEDR_W];
  assign paused = paused_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer (BASE_DIV=16, DEBOUNCE_CYC=4).
module tb_led_pattern_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       RST;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] LEDR;
  logic [7:0] LEDG;
  logic       paused;
  logic [17:0] leds;
  logic [17:0] exp_leds;

  int checks = 0;
  int errors = 0;

  assign leds = {LEDR, LEDG};

  led_pattern_sequencer #(
    .BASE_DIV     (16),
    .DEBOUNCE_CYC (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .SW       (SW),
    .KEY      (KEY),
    .LEDR     (LEDR),
    .LEDG     (LEDG),
    .paused   (paused)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the selected keys low for two cycles, then release and let it settle.
  task automatic press(input logic [3:0] mask);
    KEY = ~mask;
    step(2);
    KEY = 4'hF;
    step(4);
  endtask

  function automatic logic [17:0] onehot(input int p);
    logic [17:0] one;
    one = 18'd1;
    return one << p;
  endfunction

  initial begin
    RST = 1'b1;
    SW  = 10'h002;
    KEY = 4'hF;
    step(3);
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_paused", 32'(paused), 32'h0);
    RST = 1'b0;

    // CHASE at speed 0: first tick loads pos 0, then one step every 16 cycles.
    exp_leds = '0;
    for (int k = 1; k <= 20; k++) begin
      step(15);
      chk("chase_hold", 32'(leds), 32'(exp_leds));
      step(1);
      exp_leds = onehot((k - 1) % 18);
      chk("chase_tick", 32'(leds), 32'(exp_leds));
    end

    // BOUNCE: 0..17 then 16..0 then 1.
    SW = 10'h003;
    for (int j = 0; j <= 35; j++) begin
      int p;
      step(16);
      p = j % 34;
      exp_leds = onehot((p <= 17) ? p : 34 - p);
      chk("bounce_tick", 32'(leds), 32'(exp_leds));
    end

    // ALT, then speed 0 -> 3 landing when the counter reads 10.
    SW = 10'h001;
    step(16);
    chk("alt_load", 32'(leds), 32'h15555);
    step(8);
    SW = 10'h00D;
    step(2);
    chk("spd_hold", 32'(leds), 32'h15555);
    step(1);
    chk("spd_tick1", 32'(leds), 32'h2AAAA);
    step(1);
    chk("spd_gap1", 32'(leds), 32'h2AAAA);
    step(1);
    chk("spd_tick2", 32'(leds), 32'h15555);
    step(1);
    chk("spd_gap2", 32'(leds), 32'h15555);
    step(1);
    chk("spd_tick3", 32'(leds), 32'h2AAAA);

    // Pause and single-step in CHASE.
    SW  = 10'h002;
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(16);
    chk("p_load", 32'(leds), 32'(onehot(0)));
    step(16);
    chk("p_pos1", 32'(leds), 32'(onehot(1)));
    press(4'b0001);
    chk("p_paused", 32'(paused), 32'h1);
    step(40);
    chk("p_hold_leds", 32'(leds), 32'(onehot(1)));
    for (int i = 1; i <= 3; i++) begin
      press(4'b0010);
      chk("p_step", 32'(leds), 32'(onehot(1 + i)));
    end
    step(40);
    chk("p_no_tick", 32'(leds), 32'(onehot(4)));
    chk("p_still_paused", 32'(paused), 32'h1);

    // Unpause: counter resumes from its cleared value.
    press(4'b0001);
    chk("u_paused", 32'(paused), 32'h0);
    step(12);
    chk("u_hold", 32'(leds), 32'(onehot(4)));
    step(1);
    chk("u_tick", 32'(leds), 32'(onehot(5)));

    // Pause and step together while running.
    press(4'b0011);
    chk("both_paused", 32'(paused), 32'h1);
    chk("both_no_adv", 32'(leds), 32'(onehot(5)));
    step(30);
    chk("both_hold", 32'(leds), 32'(onehot(5)));

    for (int i = 1; i <= 4; i++) press(4'b0010);
    chk("pos9_leds", 32'(leds), 32'(onehot(9)));
    chk("pos9_ledr", 32'(LEDR), 32'h002);

    // Reset lands on the same edge as a step press.
    SW  = 10'h001;
    KEY = 4'b1101;
    step(2);
    RST = 1'b1;
    step(1);
    chk("rst_ledr", 32'(LEDR), 32'h0);
    chk("rst_ledg", 32'(LEDG), 32'h0);
    chk("rst_paused", 32'(paused), 32'h0);
    RST = 1'b0;
    KEY = 4'hF;
    step(15);
    chk("rst_hold", 32'(leds), 32'h0);
    step(1);
    chk("rst_first_tick", 32'(leds), 32'h15555);
    chk("rst_run", 32'(paused), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter BASE_DIV, default 25_000_000: clock cycles per pattern step at speed 0 (0.5 s at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 1_000_000: cycles a key level must hold stable to be accepted (used only when debounce is compiled in).
REQ-003 SHALL have one clock and a synchronous, active-high reset: port CLOCK_50, input, 1, the 50 MHz board clock, all state on its rising edge.
REQ-004 Port RST, input, 1: synchronous active-high reset.
REQ-005 Port SW, input, 10: SW[1:0] mode select, SW[3:2] speed select, SW[9:4] unused.
REQ-006 Port KEY, input, 4: active-low pushbuttons; KEY[0] pause toggle, KEY[1] single step, KEY[3:2] unused.
REQ-007 Port LEDR, output, 10: pattern bits 17..8 (LEDR[i] = bit i+8).
REQ-008 Port LEDG, output, 8: pattern bits 7..0.
REQ-009 Port paused, output, 1: high while the sequencer is paused.

Function
REQ-010 Tick generator: counter SHALL count 0..P-1 with P = BASE_DIV >> SW[3:2]; one-cycle tick when counter >= P-1; counter returns to 0 that cycle.
REQ-011 Speed change mid-count SHALL use the `>=` compare, so a shorter period whose limit is already passed ticks on the next cycle. There SHALL be no lost or double ticks.
REQ-012 SW and KEY SHALL pass through a 2-flop synchronizer. A key press is the falling edge of the synchronized level: a one-cycle pulse.
REQ-013 Mode codes: 0 OFF (all LEDs dark); 1 ALT (18'h15555 / 18'h2AAAA alternating); 2 CHASE (one lit bit walks 0->17, wraps to 0); 3 BOUNCE (one lit bit walks 0->17->0, direction flips at ends, end positions not repeated).
REQ-014 Active mode SHALL be latched from synchronized SW[1:0] only on an advance event (tick while running, or step while paused).
REQ-015 If the latched mode differs, the advance SHALL load the new mode at position 0, direction up, ALT phase 0, instead of stepping.
REQ-016 Advance SHALL step pos/dir/phase. LEDR/LEDG SHALL be registered and reflect the new state one cycle after the advance event.
REQ-017 Pause press SHALL toggle paused. While paused, the counter SHALL hold its value and tick SHALL be suppressed.
REQ-018 Step press SHALL advance exactly once only when paused was already 1 in that cycle, then clear the counter. Step while running SHALL be ignored.
REQ-019 Pause and step pressed in the same cycle: toggle applies; step is evaluated against the pre-toggle paused value.
REQ-020 Unpausing SHALL resume counting from the held counter value.

Reset
REQ-021 On RST (sampled at the clock edge) all outputs SHALL be 0 and all internal state SHALL clear: counter 0, mode OFF, pos 0, dir up, phase 0, paused 0, synchronizers and debounce state 0/released.
REQ-022 RST mid-step or while paused SHALL take priority over every other event in that cycle.
REQ-023 The first tick after reset SHALL load the SW mode per REQ-015.

Configuration
REQ-024 Macro LED_SEQ_DEBOUNCE_EN defined: each synchronized KEY SHALL pass a debouncer that accepts a new level only after DEBOUNCE_CYC consecutive equal samples; edges are detected on the accepted level.
REQ-025 Macro LED_SEQ_DEBOUNCE_EN absent: edges SHALL be detected directly on the synchronized level. DEBOUNCE_CYC is then unused.

Structure
REQ-026 Package led_seq_pkg SHALL hold the mode enum (MODE_OFF, MODE_ALT, MODE_CHASE, MODE_BOUNCE), LED_COUNT=18, ALT_PATTERN=18'h15555 and the pattern-bit-to-LED mapping constants.
REQ-027 The tick counter (period select, hold, clear) SHALL be a sub-module led_tick_gen. Pattern state, keys and mode logic SHALL stay in the top.

Verification (BASE_DIV=16, DEBOUNCE_CYC=4)
REQ-028 Bench SHALL cover this case: SW=0x002, speed 0, run 20 ticks -> lit bit walks LEDG[0]..LEDR[9] every 16 cycles, then returns to LEDG[0].
REQ-029 Bench SHALL cover this case: SW=0x003 -> after position 17 the next position is 16, and after position 0 the next is 1.
REQ-030 Bench SHALL cover this case: ALT mode, SW[3:2] changed 0->3 at counter=10 -> tick on the next cycle, then every 2 cycles.
REQ-031 Bench SHALL cover this case: press KEY[0], then KEY[1] three times -> paused=1, exactly 3 advances, no tick-driven advance.
REQ-032 Bench SHALL cover this case: KEY[0] and KEY[1] pressed in the same cycle while running -> paused=1, no advance.
REQ-033 Bench SHALL cover this case: RST asserted while paused in CHASE at position 9 -> next cycle LEDR=0, LEDG=0, paused=0. The first tick then loads SW mode at position 0.
